// File: rtl/vga_reg_snapshot.sv
// Frame-coherent shadow of DEPTH source bytes, captured at vblank into the back bank and swapped on completion.
// Read port is 1 cycle; the source bus is req/ack with a per-byte timeout, so a stalled source cannot hang a pass.
module vga_reg_snapshot #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [9:0]  VBLANK_LINE = 10'd480,
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic [9:0] y,
    input  logic       enable,
    output logic       src_req,
    output logic [7:0] src_addr,
    input  logic       src_ack,
    input  logic [7:0] src_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       frame_done,
    output logic       disp_bank,
    output logic       overrun,
    output logic       timeout_err
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_NEXT, S_SWAP} state_t;

    state_t     state_q;
    logic [9:0] y_prev_q;
    logic [7:0] idx_q;
    logic [7:0] wait_q;
    logic [7:0] rd_data_q;
    logic       src_req_q;
    logic       busy_q;
    logic       frame_done_q;
    logic       disp_bank_q;
    logic       overrun_q;
    logic       timeout_err_q;
    logic [7:0] mem_q [2][DEPTH];

    logic       trig;
    logic       wr_en;
    logic [7:0] wr_dat;
    logic       rd_in_range;

    assign trig        = (y == VBLANK_LINE) && (y_prev_q != VBLANK_LINE);
    // A byte completes on ack, or on the TIMEOUT-th REQ cycle without one.
    assign wr_en       = (state_q == S_REQ) && (src_ack || (wait_q == WAIT_LAST));
    assign wr_dat      = src_ack ? src_data : ERR_BYTE;
    assign rd_in_range = ({1'b0, rd_addr} < 9'(DEPTH));

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            y_prev_q      <= VBLANK_LINE;
            idx_q         <= 8'h00;
            wait_q        <= 8'h00;
            rd_data_q     <= 8'h00;
            src_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            disp_bank_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            y_prev_q     <= y;
            frame_done_q <= 1'b0;
            rd_data_q    <= rd_in_range ? mem_q[disp_bank_q][rd_addr[AW-1:0]] : 8'h00;
            if (trig && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trig && enable) begin
                        idx_q     <= 8'h00;
                        wait_q    <= 8'h00;
                        src_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_q <= wait_q + 8'h01;
                    if (wr_en) begin
                        src_req_q <= 1'b0;
                        state_q   <= S_NEXT;
                        if (!src_ack) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_SWAP;
                    end else begin
                        idx_q     <= idx_q + 8'h01;
                        wait_q    <= 8'h00;
                        src_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_SWAP: begin
                    disp_bank_q  <= ~disp_bank_q;
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Captures always land in the hidden bank, so the overlay never sees a half-written frame.
    always_ff @(posedge px_clk) begin
        if (wr_en && !reset) begin
            mem_q[~disp_bank_q][idx_q[AW-1:0]] <= wr_dat;
        end
    end

    assign src_req     = src_req_q;
    assign src_addr    = idx_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign disp_bank   = disp_bank_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule
